// File: rtl/mipi_csi2_pkt_ctrl_pkg.sv
// Shared constants for the CSI-2 packet sequencer: data-type codes, header byte indices and
// sequencer states.
package mipi_csi2_pkt_ctrl_pkg;

    localparam logic [5:0] DtFs      = 6'h00;
    localparam logic [5:0] DtFe      = 6'h01;
    localparam logic [5:0] DtLs      = 6'h02;
    localparam logic [5:0] DtLe      = 6'h03;
    localparam logic [5:0] DtLongMin = 6'h10;
    localparam logic [5:0] DtImgMin  = 6'h18;
    localparam logic [5:0] DtImgMax  = 6'h2F;

    localparam logic [1:0] HdrWcLo = 2'd1;
    localparam logic [1:0] HdrWcHi = 2'd2;
    localparam logic [1:0] HdrEcc  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPayload,
        StCrc,
        StWaitLp
    } state_e;

    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt >= DtLongMin;
    endfunction

    function automatic logic is_image_dt(input logic [5:0] dt);
        return (dt >= DtImgMin) && (dt <= DtImgMax);
    endfunction

endpackage

// File: rtl/mipi_csi2_ecc.sv
// CSI-2 packet header ECC generator: 6-bit Hamming parity over {WC[15:0], DI[7:0]}.
// Purely combinational so transmit-side blocks can share it.
module mipi_csi2_ecc (
    input  logic [23:0] data,
    output logic [5:0]  ecc
);

    assign ecc[0] = ^{data[0], data[1], data[2], data[4], data[5], data[7], data[10], data[11],
                      data[13], data[16], data[20], data[21], data[22], data[23]};
    assign ecc[1] = ^{data[0], data[1], data[3], data[4], data[6], data[8], data[10], data[12],
                      data[14], data[17], data[20], data[21], data[22], data[23]};
    assign ecc[2] = ^{data[0], data[2], data[3], data[5], data[6], data[9], data[11], data[12],
                      data[15], data[18], data[20], data[21], data[22]};
    assign ecc[3] = ^{data[1], data[2], data[3], data[7], data[8], data[9], data[13], data[14],
                      data[15], data[19], data[20], data[21], data[23]};
    assign ecc[4] = ^{data[4], data[5], data[6], data[7], data[8], data[9], data[16], data[17],
                      data[18], data[19], data[20], data[22], data[23]};
    assign ecc[5] = ^{data[10], data[11], data[12], data[13], data[14], data[15], data[16],
                      data[17], data[18], data[19], data[21], data[22], data[23]};

endmodule

// File: rtl/mipi_csi2_pkt_ctrl.sv
// CSI-2 packet sequencer on the single-lane PHY byte stream: parses the 4-byte header, steps the
// payload by word count, skips the CRC and produces frame/line framing plus pixel-byte strobes.
module mipi_csi2_pkt_ctrl
    import mipi_csi2_pkt_ctrl_pkg::*;
#(
    parameter bit          ECC_CHECK = 1'b1,
    parameter logic [1:0]  VC_SEL    = 2'd0,
    parameter int unsigned MAX_WC    = 4096
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        phy_we,
    input  logic [7:0]  phy_data,
    output logic        fv,
    output logic        lv,
    output logic        dout_valid,
    output logic [7:0]  dout,
    output logic [5:0]  data_type,
    output logic [15:0] line_cnt,
    output logic        pkt_err
);

    state_e      state;
    logic [1:0]  hdr_idx;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [15:0] byte_cnt;
    logic        crc_idx;

    logic [5:0]  ecc_calc;
    logic        ecc_ok;
    logic        hdr_long;
    logic        wc_too_big;
    logic        hdr_bad;

    // At the ECC byte, DI and both WC bytes are already registered.
    mipi_csi2_ecc u_ecc (
        .data ({wc, di}),
        .ecc  (ecc_calc)
    );

    always_comb begin
        ecc_ok     = (phy_data[7:6] == 2'b00) && (phy_data[5:0] == ecc_calc);
        hdr_long   = is_long_dt(di[5:0]);
        wc_too_big = hdr_long && (32'(wc) > MAX_WC);
        hdr_bad    = (ECC_CHECK && !ecc_ok) || wc_too_big;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state      <= StIdle;
            hdr_idx    <= 2'd0;
            di         <= 8'd0;
            wc         <= 16'd0;
            byte_cnt   <= 16'd0;
            crc_idx    <= 1'b0;
            fv         <= 1'b0;
            lv         <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= 8'd0;
            data_type  <= 6'd0;
            line_cnt   <= 16'd0;
            pkt_err    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            pkt_err    <= 1'b0;
            case (state)
                StIdle: begin
                    lv <= 1'b0;
                    if (phy_we) begin
                        di      <= phy_data;
                        hdr_idx <= HdrWcLo;
                        state   <= StHdr;
                    end
                end

                StHdr: begin
                    if (!phy_we) begin
                        pkt_err <= 1'b1;
                        lv      <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        case (hdr_idx)
                            HdrWcLo: begin
                                wc[7:0] <= phy_data;
                                hdr_idx <= HdrWcHi;
                            end
                            HdrWcHi: begin
                                wc[15:8] <= phy_data;
                                hdr_idx  <= HdrEcc;
                            end
                            default: begin
                                hdr_idx <= 2'd0;
                                if (hdr_bad) begin
                                    pkt_err <= 1'b1;
                                    state   <= StWaitLp;
                                end else if (di[7:6] != VC_SEL) begin
                                    state <= StWaitLp;
                                end else begin
                                    data_type <= di[5:0];
                                    if (hdr_long) begin
                                        if (wc == 16'd0) begin
                                            crc_idx <= 1'b0;
                                            state   <= StCrc;
                                        end else begin
                                            byte_cnt <= wc;
                                            state    <= StPayload;
                                        end
                                    end else begin
                                        // Short packet WC carries a frame/line number only.
                                        if (di[5:0] == DtFs) begin
                                            fv       <= 1'b1;
                                            line_cnt <= 16'd0;
                                        end else if (di[5:0] == DtFe) begin
                                            fv <= 1'b0;
                                        end
                                        state <= StWaitLp;
                                    end
                                end
                            end
                        endcase
                    end
                end

                StPayload: begin
                    if (!phy_we) begin
                        pkt_err <= 1'b1;
                        lv      <= 1'b0;
                        state   <= StIdle;
                    end else begin
                        dout       <= phy_data;
                        dout_valid <= 1'b1;
                        lv         <= is_image_dt(data_type);
                        byte_cnt   <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) begin
                            crc_idx <= 1'b0;
                            state   <= StCrc;
                        end
                    end
                end

                StCrc: begin
                    lv <= 1'b0;
                    if (!phy_we) begin
                        pkt_err <= 1'b1;
                        state   <= StIdle;
                    end else if (!crc_idx) begin
                        crc_idx <= 1'b1;
                    end else begin
                        if (is_image_dt(data_type) && (line_cnt != 16'hFFFF)) begin
                            line_cnt <= line_cnt + 16'd1;
                        end
                        state <= StWaitLp;
                    end
                end

                StWaitLp: begin
                    // Trailer bytes until LP are swallowed, never parsed as a header.
                    lv <= 1'b0;
                    if (!phy_we) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    lv    <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_csi2_pkt_ctrl.sv
// Bench for mipi_csi2_pkt_ctrl: directed bursts plus random bursts scored against a
// packet-level reference model.
module tb_mipi_csi2_pkt_ctrl;

    localparam int unsigned MAX_WC = 4096;
    localparam logic [1:0]  VC_SEL = 2'd0;

    // Hamming column code of each header bit {WC, DI}.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    logic        clk = 1'b0;
    logic        resetb;
    logic        phy_we;
    logic [7:0]  phy_data;
    logic        fv;
    logic        lv;
    logic        dout_valid;
    logic [7:0]  dout;
    logic [5:0]  data_type;
    logic [15:0] line_cnt;
    logic        pkt_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] obs_d[$];
    logic       obs_lv[$];
    int         obs_c[$];
    int         err_seen = 0;
    int         lv_stray = 0;

    logic [7:0]  bq[$];
    logic [7:0]  exp_d[$];
    logic        exp_lv;
    int          exp_err;
    logic        m_fv;
    logic [15:0] m_line;
    logic [5:0]  m_dt;

    mipi_csi2_pkt_ctrl #(
        .ECC_CHECK (1'b1),
        .VC_SEL    (VC_SEL),
        .MAX_WC    (MAX_WC)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .phy_we     (phy_we),
        .phy_data   (phy_data),
        .fv         (fv),
        .lv         (lv),
        .dout_valid (dout_valid),
        .dout       (dout),
        .data_type  (data_type),
        .line_cnt   (line_cnt),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            obs_d.push_back(dout);
            obs_lv.push_back(lv);
            obs_c.push_back(cyc);
        end
        if (lv && !dout_valid) lv_stray++;
        if (pkt_err) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return e;
    endfunction

    task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] flip);
        bq.push_back(di);
        bq.push_back(wc[7:0]);
        bq.push_back(wc[15:8]);
        bq.push_back({2'b00, ref_ecc({wc, di})} ^ flip);
    endtask

    task automatic push_long(input logic [7:0] di, input int wc, input logic [7:0] flip);
        push_hdr(di, 16'(wc), flip);
        for (int i = 0; i < wc + 2; i++) bq.push_back(8'($urandom));
    endtask

    // Packet-level expectations for the burst in bq; updates the frame/line model state.
    task automatic model_burst();
        int n;
        logic [7:0] di;
        logic [7:0] ec;
        int wc;
        logic [5:0] dt;
        logic is_long;
        logic img;
        n = bq.size();
        exp_d.delete();
        exp_lv = 1'b0;
        exp_err = 0;
        if (n == 0) return;
        if (n < 4) begin
            exp_err = 1;
            return;
        end
        di = bq[0];
        wc = int'({bq[2], bq[1]});
        ec = bq[3];
        dt = di[5:0];
        is_long = dt >= 6'h10;
        if (ec != {2'b00, ref_ecc({bq[2], bq[1], di})} || (is_long && wc > int'(MAX_WC))) begin
            exp_err = 1;
            return;
        end
        if (di[7:6] != VC_SEL) return;
        m_dt = dt;
        if (!is_long) begin
            if (dt == 6'h00) begin
                m_fv = 1'b1;
                m_line = 16'd0;
            end else if (dt == 6'h01) begin
                m_fv = 1'b0;
            end
            return;
        end
        img = (dt >= 6'h18) && (dt <= 6'h2F);
        exp_lv = img;
        for (int i = 0; i < wc && 4 + i < n; i++) exp_d.push_back(bq[4 + i]);
        if (n - 4 < wc + 2) exp_err = 1;
        else if (img && m_line != 16'hFFFF) m_line = m_line + 16'd1;
    endtask

    task automatic run_burst(input string tag);
        int n;
        int b0;
        int e0;
        int s0;
        logic prev_fv;
        int drv_cyc[$];
        n = bq.size();
        b0 = obs_d.size();
        e0 = err_seen;
        s0 = lv_stray;
        prev_fv = m_fv;
        model_burst();
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (n >= 4 && i == 3) chk({tag, " fv_before_ecc"}, fv, prev_fv);
            if (n >= 4 && i == 4) chk({tag, " fv_after_ecc"}, fv, m_fv);
            if (i < n) begin
                phy_we = 1'b1;
                phy_data = bq[i];
                drv_cyc.push_back(cyc);
            end else begin
                phy_we = 1'b0;
                phy_data = 8'($urandom);
            end
        end
        repeat (3) @(negedge clk);
        chk({tag, " dout_count"}, obs_d.size() - b0, exp_d.size());
        for (int k = 0; k < exp_d.size() && b0 + k < obs_d.size(); k++) begin
            chk($sformatf("%s dout[%0d]", tag, k), obs_d[b0 + k], exp_d[k]);
            chk($sformatf("%s lv[%0d]", tag, k), obs_lv[b0 + k], exp_lv);
            chk($sformatf("%s lag[%0d]", tag, k), obs_c[b0 + k], drv_cyc[4 + k] + 1);
        end
        chk({tag, " pkt_err_pulses"}, err_seen - e0, exp_err);
        chk({tag, " fv"}, fv, m_fv);
        chk({tag, " line_cnt"}, line_cnt, m_line);
        chk({tag, " data_type"}, data_type, m_dt);
        chk({tag, " lv_without_valid"}, lv_stray - s0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " fv"}, fv, 0);
        chk({tag, " lv"}, lv, 0);
        chk({tag, " dout_valid"}, dout_valid, 0);
        chk({tag, " dout"}, dout, 0);
        chk({tag, " data_type"}, data_type, 0);
        chk({tag, " line_cnt"}, line_cnt, 0);
        chk({tag, " pkt_err"}, pkt_err, 0);
    endtask

    initial begin
        int kind;
        int wc;
        int cut;
        int b0;
        int e0;
        logic [7:0] di;

        resetb = 1'b0;
        phy_we = 1'b0;
        phy_data = 8'd0;
        m_fv = 1'b0;
        m_line = 16'd0;
        m_dt = 6'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        bq.delete(); push_hdr(8'h00, 16'h0001, 8'h00);
        run_burst("t1_fs");

        bq.delete(); push_hdr(8'h2A, 16'd4, 8'h00);
        bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33); bq.push_back(8'h44);
        bq.push_back(8'hC3); bq.push_back(8'h5E);
        bq.push_back(8'h00); bq.push_back(8'h01); bq.push_back(8'h1A);
        run_burst("t2_raw8");

        bq.delete(); push_hdr(8'h2A, 16'd4, 8'h04);
        bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33); bq.push_back(8'h44);
        bq.push_back(8'hC3); bq.push_back(8'h5E);
        run_burst("t3_bad_ecc");

        bq.delete(); push_hdr(8'h2A, 16'd8, 8'h00);
        bq.push_back(8'hA1); bq.push_back(8'hB2); bq.push_back(8'hC3);
        run_burst("t4_trunc");
        bq.delete(); push_long(8'h2A, 5, 8'h00);
        run_burst("t4_next");

        bq.delete(); push_long(8'h6A, 6, 8'h00);
        run_burst("t5_vc1_long");
        bq.delete(); push_hdr(8'h41, 16'd3, 8'h00);
        run_burst("t5_vc1_fe");
        bq.delete(); push_hdr(8'h01, 16'd3, 8'h00);
        run_burst("t5_fe");

        bq.delete(); push_hdr(8'h00, 16'd2, 8'h00);
        run_burst("b_fs");
        bq.delete(); push_long(8'h2B, 0, 8'h00);
        run_burst("b_wc0");
        bq.delete(); push_hdr(8'h2A, 16'(MAX_WC), 8'h00);
        bq.push_back(8'h3C); bq.push_back(8'hC3);
        run_burst("b_wc_max");
        bq.delete(); push_hdr(8'h2A, 16'(MAX_WC + 1), 8'h00);
        bq.push_back(8'h3C); bq.push_back(8'hC3);
        run_burst("b_wc_over");
        bq.delete(); push_hdr(8'h01, 16'd9, 8'h00);
        run_burst("b_fe");
        bq.delete(); push_hdr(8'h01, 16'd9, 8'h00);
        run_burst("b_fe_again");

        for (int r = 0; r < 80; r++) begin
            bq.delete();
            kind = $urandom_range(0, 9);
            wc = $urandom_range(0, 12);
            case (kind)
                0: push_hdr(8'h00, 16'($urandom), 8'h00);
                1: push_hdr(8'h01, 16'($urandom), 8'h00);
                2: push_hdr({2'b00, 6'($urandom_range(2, 15))}, 16'($urandom), 8'h00);
                3, 4, 5: push_long({2'b00, 6'($urandom_range(24, 47))}, wc, 8'h00);
                6: begin
                    if ($urandom_range(0, 1) == 0) di = {2'b00, 6'($urandom_range(16, 23))};
                    else di = {2'b00, 6'($urandom_range(48, 63))};
                    push_long(di, wc, 8'h00);
                end
                7: push_long({2'b00, 6'($urandom_range(24, 47))}, wc,
                             8'(1 << $urandom_range(0, 7)));
                8: begin
                    push_long({2'b00, 6'($urandom_range(16, 47))}, wc + 1, 8'h00);
                    cut = $urandom_range(1, wc + 6);
                    while (bq.size() > cut) void'(bq.pop_back());
                end
                default: push_long({2'($urandom_range(1, 3)), 6'($urandom_range(0, 47))}, wc,
                                   8'h00);
            endcase
            if (kind != 8) begin
                repeat ($urandom_range(0, 3)) bq.push_back(8'($urandom));
            end
            run_burst($sformatf("rnd%0d_k%0d", r, kind));
        end

        bq.delete(); push_hdr(8'h00, 16'd7, 8'h00);
        run_burst("t6_fs");
        bq.delete(); push_hdr(8'h2A, 16'd8, 8'h00);
        bq.push_back(8'hA5); bq.push_back(8'h5A);
        b0 = obs_d.size();
        e0 = err_seen;
        foreach (bq[i]) begin
            @(negedge clk);
            phy_we = 1'b1;
            phy_data = bq[i];
        end
        @(negedge clk);
        resetb = 1'b0;
        phy_data = 8'h77;
        @(negedge clk);
        chk_zero("t6_reset");
        resetb = 1'b1;
        phy_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6 bytes_before_reset", obs_d.size() - b0, 2);
        chk("t6 no_err_on_reset", err_seen - e0, 0);
        m_fv = 1'b0;
        m_line = 16'd0;
        m_dt = 6'd0;
        bq.delete(); push_long(8'h2B, 5, 8'h00);
        run_burst("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
